pll_rst_seq: RTL and testbench

Multi-PLL reset and lock sequencer for the LVDS RX/TX clocking path. Pulses the PLL resets and waits for every PLL to report a stable lock, retrying on timeout. It then releases downstream domain resets in a staggered order. If any lock is lost it tears everything down and restarts, and it reports ready, fail and diagnostic counters.

---
 rtl/pll_rst_seq.sv | 202 ++++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_rst_seq
//  Description : Multi-PLL reset and lock sequencer. Pulses the PLL resets,
//                waits for every PLL to hold lock for LOCK_FILT cycles and
//                retries if lock does not arrive in time. It then releases the
//                downstream domain resets one after another, DOM_GAP cycles
//                apart. A lock drop tears everything down and restarts.
//  Ports       : clk           - free-running system clock
//                rst_n         - synchronous active-low reset
//                pll_lock      - raw (asynchronous) PLL lock indications
//                force_rst     - single-cycle software restart request
//                pll_rst       - active-high reset to every PLL (bits equal)
//                dom_rst_n     - active-low resets to downstream domains
//                ready         - all domains released and PLLs locked
//                fail          - retry budget exhausted
//                state         - current FSM state encoding
//                retry_cnt     - timeouts since last good lock / force_rst
//                lock_loss_cnt - lock drops seen in RUN, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq #(
  parameter int NUM_PLL   = 2,
  parameter int NUM_DOM   = 3,
  parameter int RST_CYC   = 16,
  parameter int LOCK_FILT = 64,
  parameter int LOCK_TMO  = 65535,
  parameter int DOM_GAP   = 8,
  parameter int MAX_RETRY = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PLL-1:0] pll_lock,
  input  logic               force_rst,
  output logic [NUM_PLL-1:0] pll_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [2:0]         state,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  localparam logic [2:0] c_RESET_PLL = 3'd0;
  localparam logic [2:0] c_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_FILTER    = 3'd2;
  localparam logic [2:0] c_RELEASE   = 3'd3;
  localparam logic [2:0] c_RUN       = 3'd4;
  localparam logic [2:0] c_FAIL      = 3'd5;

  localparam logic [15:0] c_RST_END  = 16'(RST_CYC - 1);
  localparam logic [15:0] c_TMO_END  = 16'(LOCK_TMO - 1);
  localparam logic [15:0] c_FILT_END = 16'(LOCK_FILT - 1);
  localparam logic [15:0] c_REL_END  = 16'((NUM_DOM - 1) * DOM_GAP);
  localparam logic [3:0]  c_MAX_RTRY = 4'(MAX_RETRY);

  logic [NUM_PLL-1:0] r_sync1;
  logic [NUM_PLL-1:0] r_sync2;
  logic               w_lock_all;

  logic [2:0]         r_state;
  logic [15:0]        r_tmr;
  logic [3:0]         r_retry;
  logic [7:0]         r_llc;

  logic [2:0]         w_nxt_state;
  logic [15:0]        w_nxt_tmr;
  logic [3:0]         w_nxt_retry;
  logic [7:0]         w_nxt_llc;
  logic [NUM_DOM-1:0] w_nxt_dom;

  // Two-flop synchroniser per lock bit; decisions only ever see the AND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_all = &r_sync2;

  // Next-state logic. One shared timer serves every state: RESET_PLL pulse
  // width, WAIT_LOCK timeout, FILTER consecutive-lock count and RELEASE
  // stagger position.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tmr   = r_tmr + 16'd1;
    w_nxt_retry = r_retry;
    w_nxt_llc   = r_llc;
    if (force_rst) begin
      w_nxt_state = c_RESET_PLL;
      w_nxt_tmr   = 16'd0;
      w_nxt_retry = 4'd0;
    end else begin
      case (r_state)
        c_RESET_PLL: begin
          if (r_tmr == c_RST_END) begin
            w_nxt_state = c_WAIT_LOCK;
            w_nxt_tmr   = 16'd0;
          end
        end
        c_WAIT_LOCK: begin
          if (w_lock_all) begin
            // This cycle already counts as the first clean lock cycle.
            w_nxt_state = c_FILTER;
            w_nxt_tmr   = 16'd1;
          end else if (r_tmr == c_TMO_END) begin
            w_nxt_tmr = 16'd0;
            if (r_retry == c_MAX_RTRY) begin
              w_nxt_state = c_FAIL;
            end else begin
              w_nxt_state = c_RESET_PLL;
              w_nxt_retry = r_retry + 4'd1;
            end
          end
        end
        c_FILTER: begin
          if (!w_lock_all) begin
            w_nxt_state = c_WAIT_LOCK;
            w_nxt_tmr   = 16'd0;
          end else if (r_tmr >= c_FILT_END) begin
            w_nxt_state = c_RELEASE;
            w_nxt_tmr   = 16'd0;
            w_nxt_retry = 4'd0;
          end
        end
        c_RELEASE: begin
          if (!w_lock_all) begin
            w_nxt_state = c_RESET_PLL;
            w_nxt_tmr   = 16'd0;
          end else if (r_tmr == c_REL_END) begin
            w_nxt_state = c_RUN;
            w_nxt_tmr   = 16'd0;
          end
        end
        c_RUN: begin
          w_nxt_tmr = 16'd0;
          if (!w_lock_all) begin
            w_nxt_state = c_RESET_PLL;
            if (r_llc != 8'hFF) begin
              w_nxt_llc = r_llc + 8'd1;
            end
          end
        end
        c_FAIL: begin
          w_nxt_tmr = 16'd0;
        end
        default: begin
          w_nxt_state = c_RESET_PLL;
          w_nxt_tmr   = 16'd0;
        end
      endcase
    end
  end

  // Domain k is released once the RELEASE timer reaches k*DOM_GAP, and all
  // domains stay released in RUN.
  genvar k;
  generate
    for (k = 0; k < NUM_DOM; k++) begin : g_dom
      if (k == 0) begin : g_first
        assign w_nxt_dom[k] = (w_nxt_state == c_RUN) || (w_nxt_state == c_RELEASE);
      end else begin : g_rest
        assign w_nxt_dom[k] = (w_nxt_state == c_RUN) ||
                              ((w_nxt_state == c_RELEASE) && (w_nxt_tmr >= 16'(k * DOM_GAP)));
      end
    end
  endgenerate

  // Outputs are registered from the next-state values so they line up with
  // the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_RESET_PLL;
      r_tmr     <= 16'd0;
      r_retry   <= 4'd0;
      r_llc     <= 8'd0;
      pll_rst   <= '1;
      dom_rst_n <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_tmr     <= w_nxt_tmr;
      r_retry   <= w_nxt_retry;
      r_llc     <= w_nxt_llc;
      pll_rst   <= {NUM_PLL{(w_nxt_state == c_RESET_PLL) || (w_nxt_state == c_FAIL)}};
      dom_rst_n <= w_nxt_dom;
      ready     <= (w_nxt_state == c_RUN);
      fail      <= (w_nxt_state == c_FAIL);
    end
  end

  assign state         = r_state;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_llc;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_rst_seq
//  Description : Testbench for pll_rst_seq. A reference model predicts the
//                outputs after every clock edge and queues them; a separate
//                monitor pops and compares them against the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

  localparam int NUM_PLL   = 2;
  localparam int NUM_DOM   = 3;
  localparam int RST_CYC   = 4;
  localparam int LOCK_FILT = 8;
  localparam int LOCK_TMO  = 20;
  localparam int DOM_GAP   = 2;
  localparam int MAX_RETRY = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_PLL-1:0] pll_lock = '0;
  logic               force_rst = 1'b0;
  logic [NUM_PLL-1:0] pll_rst;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               ready;
  logic               fail;
  logic [2:0]         state;
  logic [3:0]         retry_cnt;
  logic [7:0]         lock_loss_cnt;

  pll_rst_seq #(
    .NUM_PLL(NUM_PLL), .NUM_DOM(NUM_DOM), .RST_CYC(RST_CYC), .LOCK_FILT(LOCK_FILT),
    .LOCK_TMO(LOCK_TMO), .DOM_GAP(DOM_GAP), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .force_rst(force_rst),
    .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .ready(ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]         st;
    logic [NUM_PLL-1:0] prst;
    logic [NUM_DOM-1:0] dom;
    logic               rdy;
    logic               fl;
    logic [3:0]         rc;
    logic [7:0]         llc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: phase number, cycles spent in the phase, length of the
  // current run of all-locked cycles, counters, and the sync pipeline.
  int               m_state = 0;
  int               m_age   = 0;
  int               m_run   = 0;
  int               m_retry = 0;
  int               m_llc   = 0;
  logic [NUM_PLL-1:0] m_s1 = '0;
  logic [NUM_PLL-1:0] m_s2 = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  task automatic enter(input int s);
    m_state = s;
    m_age   = 0;
    m_run   = 0;
  endtask

  task automatic model(input logic rn, input logic fr, input logic [NUM_PLL-1:0] lk);
    logic la;
    exp_t e;
    la = &m_s2;
    if (!rn) begin
      enter(0);
      m_retry = 0;
      m_llc   = 0;
      m_s1    = '0;
      m_s2    = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = lk;
      if (fr) begin
        enter(0);
        m_retry = 0;
      end else begin
        case (m_state)
          0: if (m_age + 1 == RST_CYC) enter(1); else m_age++;
          1, 2: begin
            if (la) begin
              m_run++;
              if (m_run >= LOCK_FILT) begin
                enter(3);
                m_retry = 0;
              end else begin
                m_state = 2;
              end
            end else if (m_state == 2) begin
              enter(1);
            end else if (m_age + 1 == LOCK_TMO) begin
              if (m_retry == MAX_RETRY) enter(5);
              else begin
                m_retry++;
                enter(0);
              end
            end else begin
              m_age++;
            end
          end
          3: if (!la) enter(0);
             else if (m_age == (NUM_DOM - 1) * DOM_GAP) enter(4);
             else m_age++;
          4: if (!la) begin
               enter(0);
               if (m_llc < 255) m_llc++;
             end
          default: ;
        endcase
      end
    end
    e.st   = 3'(m_state);
    e.prst = (m_state == 0 || m_state == 5) ? '1 : '0;
    for (int i = 0; i < NUM_DOM; i++)
      e.dom[i] = (m_state == 4) || (m_state == 3 && m_age >= i * DOM_GAP);
    e.rdy  = (m_state == 4);
    e.fl   = (m_state == 5);
    e.rc   = 4'(m_retry);
    e.llc  = 8'(m_llc);
    q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic fr, input logic [NUM_PLL-1:0] lk);
    @(negedge clk);
    rst_n     = rn;
    force_rst = fr;
    pll_lock  = lk;
    model(rn, fr, lk);
  endtask

  task automatic run_until(input int tgt, input logic [NUM_PLL-1:0] lk, input int budget);
    int n;
    n = 0;
    while (m_state != tgt) begin
      if (n == budget) begin
        checks++;
        errors++;
        $display("FAIL wait_state: model state %0d, wanted %0d within %0d cycles", m_state, tgt, budget);
        return;
      end
      step(1'b1, 1'b0, lk);
      n++;
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",         32'(state),         32'(e.st));
        chk("pll_rst",       32'(pll_rst),       32'(e.prst));
        chk("dom_rst_n",     32'(dom_rst_n),     32'(e.dom));
        chk("ready",         32'(ready),         32'(e.rdy));
        chk("fail",          32'(fail),          32'(e.fl));
        chk("retry_cnt",     32'(retry_cnt),     32'(e.rc));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.llc));
      end
    end
  end

  initial begin
    int n;
    // Bring-up with both locks high from reset.
    repeat (3) step(1'b0, 1'b0, 2'b11);
    run_until(4, 2'b11, 100);
    repeat (5) step(1'b1, 1'b0, 2'b11);

    // Only lock[1]: retries then FAIL.
    step(1'b1, 1'b1, 2'b10);
    run_until(5, 2'b10, 300);
    repeat (10) step(1'b1, 1'b0, 2'b11);
    @(posedge clk); #2;
    chk("fail_held", 32'(fail), 32'd1);

    // Recover from FAIL with force_rst.
    step(1'b1, 1'b1, 2'b11);
    run_until(4, 2'b11, 100);
    repeat (3) step(1'b1, 1'b0, 2'b11);

    // One-cycle lock drop in RUN.
    step(1'b1, 1'b0, 2'b10);
    repeat (2) step(1'b1, 1'b0, 2'b11);
    @(posedge clk); #2;
    chk("drop_ready", 32'(ready), 32'd0);
    run_until(4, 2'b11, 100);

    // Glitch during FILTER at count 5.
    step(1'b1, 1'b1, 2'b11);
    n = 0;
    while (!(m_state == 2 && m_run == 5) && n < 100) begin
      step(1'b1, 1'b0, 2'b11);
      n++;
    end
    chk("reach_filter5", 32'(m_state == 2 && m_run == 5), 32'd1);
    step(1'b1, 1'b0, 2'b01);
    run_until(4, 2'b11, 100);

    // Randomised stretch.
    for (int i = 0; i < 1500; i++) begin
      logic [NUM_PLL-1:0] lk;
      lk = ($urandom_range(0, 9) == 0) ? NUM_PLL'($urandom) : '1;
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 199) == 0), lk);
    end

    // Saturate the lock-loss counter.
    for (int i = 0; i < 260; i++) begin
      run_until(4, 2'b11, 200);
      step(1'b1, 1'b0, 2'b01);
      repeat (2) step(1'b1, 1'b0, 2'b11);
    end
    @(posedge clk); #2;
    chk("llc_sat", 32'(lock_loss_cnt), 32'd255);

    // Reset in the middle of RELEASE.
    n = 0;
    while (!(m_state == 3 && m_age == 2) && n < 100) begin
      step(1'b1, 1'b0, 2'b11);
      n++;
    end
    step(1'b0, 1'b0, 2'b11);
    @(posedge clk); #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pll_rst", 32'(pll_rst), 32'h3);
    chk("rst_dom", 32'(dom_rst_n), 32'd0);
    chk("rst_llc", 32'(lock_loss_cnt), 32'd0);
    run_until(4, 2'b11, 100);
    repeat (3) step(1'b1, 1'b0, 2'b11);

    @(posedge clk); #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
